chacha_block_scheduler: RTL and testbench

Sequences the ChaCha keystream core for streaming encryption. Issues one core start per 64-byte block, advances the 32-bit block position, and XORs incoming plaintext bytes with core keystream bytes into a registered ciphertext stream. It discards the keystream left over when a message ends mid-block. It sits between the SPI-loaded key/nonce/position registers and the byte-wide data pins, replacing hard-wired start sequencing.

---
 rtl/chacha_block_scheduler_pkg.sv | 21 ++
 rtl/chacha_ct_outreg.sv | 31 +++
 rtl/chacha_block_scheduler.sv | 132 +++++++++++++
 tb/tb_chacha_block_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/chacha_block_scheduler_pkg.sv
// Shared state encoding, ciphertext beat type and default sizing for the ChaCha block scheduler.
// Pure declarations; no logic, no latency, no flow control.
package chacha_sched_pkg;

  localparam int CHACHA_BLOCK_BYTES = 64;
  localparam int CHACHA_CTR_W       = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_ERR
  } sched_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } ct_beat_t;

endpackage

// File: rtl/chacha_ct_outreg.sv
// One-entry registered valid/ready stage holding the next ciphertext beat.
// Load lands 1 cycle later; a full slot with ct_ready low holds its beat and reports slot_free=0.
module chacha_ct_outreg
  import chacha_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  ct_beat_t load_beat,
  input  logic     ct_ready,
  output logic     ct_valid,
  output ct_beat_t ct_beat,
  output logic     slot_free
);

  assign slot_free = !ct_valid || ct_ready;

  // A load may coincide with the downstream handshake, giving 1 beat/clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct_valid <= 1'b0;
      ct_beat  <= '0;
    end else if (load) begin
      ct_valid <= 1'b1;
      ct_beat  <= load_beat;
    end else if (ct_ready) begin
      ct_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha_block_scheduler.sv
// Starts the ChaCha core once per block, advances the block position and XORs pt with keystream into ct.
// pt->ct latency 1 cycle; pt/keystream stall while the ct slot is full. Option: CHACHA_CTR_WRAP_EN.
module chacha_block_scheduler
  import chacha_sched_pkg::*;
#(
  parameter int BLOCK_BYTES = CHACHA_BLOCK_BYTES,
  parameter int CTR_W       = CHACHA_CTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_go,
  input  logic [CTR_W-1:0] cfg_position,
  output logic             core_start,
  output logic [CTR_W-1:0] core_position,
  input  logic             core_ks_valid,
  input  logic [7:0]       core_ks_byte,
  output logic             core_ks_ready,
  input  logic             pt_valid,
  input  logic [7:0]       pt_byte,
  input  logic             pt_last,
  output logic             pt_ready,
  output logic             ct_valid,
  output logic [7:0]       ct_byte,
  output logic             ct_last,
  input  logic             ct_ready,
  output logic             busy,
  output logic             done,
  output logic             err_wrap
);

  localparam int CNT_W = $clog2(BLOCK_BYTES);

`ifdef CHACHA_CTR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  sched_state_t     state;
  logic [CNT_W-1:0] byte_cnt;
  logic [CTR_W-1:0] position;
  logic             slot_free;
  logic             fire;
  logic             block_end;
  logic             overflow;
  ct_beat_t         fire_beat;
  ct_beat_t         ct_beat;

  assign fire      = (state == S_STREAM) && pt_valid && core_ks_valid && slot_free;
  assign block_end = (byte_cnt == CNT_W'(BLOCK_BYTES - 1));
  assign overflow  = (&position) && !WRAP_EN;
  assign fire_beat = '{last: pt_last, dat: pt_byte ^ core_ks_byte};

  // Plaintext and keystream move in lockstep while streaming; only DRAIN takes keystream alone.
  assign pt_ready      = fire;
  assign core_ks_ready = fire || (state == S_DRAIN);
  assign busy          = (state != S_IDLE);
  assign core_position = position;
  assign ct_byte       = ct_beat.dat;
  assign ct_last       = ct_beat.last;

  chacha_ct_outreg u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fire),
    .load_beat (fire_beat),
    .ct_ready  (ct_ready),
    .ct_valid  (ct_valid),
    .ct_beat   (ct_beat),
    .slot_free (slot_free)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      position   <= '0;
      byte_cnt   <= '0;
      core_start <= 1'b0;
      done       <= 1'b0;
      err_wrap   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_go) begin
            position   <= cfg_position;
            byte_cnt   <= '0;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: state <= S_STREAM;
        S_STREAM: begin
          if (fire) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (pt_last && !block_end) begin
              state <= S_DRAIN;
            end else if (block_end) begin
              // Every completed block advances the position, including the final one.
              if (overflow) begin
                state    <= S_ERR;
                err_wrap <= 1'b1;
              end else begin
                position <= position + CTR_W'(1);
                if (pt_last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end else begin
                  state      <= S_START;
                  core_start <= 1'b1;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          if (core_ks_valid) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (block_end) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_scheduler.sv
// Randomized directed bench for chacha_block_scheduler against a message-level reference model.
module tb_chacha_block_scheduler;

  localparam int BB = 64;

  logic        clk = 1'b0;
  logic        rst_n, cfg_go;
  logic [31:0] cfg_position;
  logic        core_start;
  logic [31:0] core_position;
  logic        core_ks_valid, core_ks_ready;
  logic [7:0]  core_ks_byte;
  logic        pt_valid, pt_last, pt_ready;
  logic [7:0]  pt_byte;
  logic        ct_valid, ct_last, ct_ready;
  logic [7:0]  ct_byte;
  logic        busy, done, err_wrap;

  int tests = 0;
  int fails = 0;

  bit          ks_const;
  logic [31:0] ks_pos;
  int          ks_idx, ks_left;
  logic [7:0]  pt_arr[$];
  logic [8:0]  exp_q[$];
  logic [31:0] start_q[$];
  int          n_start, n_done, n_drain, n_ct, pi, cyc, done_cyc, last_hs_cyc;

  always #5 clk = ~clk;

  chacha_block_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_go(cfg_go), .cfg_position(cfg_position),
    .core_start(core_start), .core_position(core_position),
    .core_ks_valid(core_ks_valid), .core_ks_byte(core_ks_byte), .core_ks_ready(core_ks_ready),
    .pt_valid(pt_valid), .pt_byte(pt_byte), .pt_last(pt_last), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_byte(ct_byte), .ct_last(ct_last), .ct_ready(ct_ready),
    .busy(busy), .done(done), .err_wrap(err_wrap)
  );

  // Keystream the modelled core produces for block 'pos', byte 'idx'.
  function automatic logic [7:0] ksfun(input logic [31:0] pos, input int idx);
    logic [7:0] a;
    logic [7:0] b;
    a = pos[7:0] ^ pos[31:24] ^ pos[15:8];
    b = 8'(idx);
    if (ks_const) return 8'hA5;
    return (a * 8'd29) ^ (b * 8'd13) ^ 8'h3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_core_start"}, core_start, 0);
    chk({t, "_core_position"}, core_position, 0);
    chk({t, "_core_ks_ready"}, core_ks_ready, 0);
    chk({t, "_pt_ready"}, pt_ready, 0);
    chk({t, "_ct_valid"}, ct_valid, 0);
    chk({t, "_ct_byte"}, ct_byte, 0);
    chk({t, "_ct_last"}, ct_last, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_err_wrap"}, err_wrap, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; cfg_go = 1'b0; pt_valid = 1'b0; core_ks_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one message of L bytes from block position P, starting and ending at a negedge.
  task automatic run_msg(input logic [31:0] P, input int L, input int abort_at, input int go_at,
                         input int hold_at, input bit expect_err, input int budget);
    bit pt_hs, ks_hs, ct_hs, stall_prev, go_done, go_chk, hold_done;
    logic [8:0]  held;
    logic [31:0] pos_before, s0;
    int hold_left, exp_starts;
    pt_arr.delete(); exp_q.delete(); start_q.delete();
    n_start = 0; n_done = 0; n_drain = 0; n_ct = 0; pi = 0; cyc = 0;
    done_cyc = -100; last_hs_cyc = -100; ks_left = 0; ks_idx = 0;
    stall_prev = 0; go_done = 0; go_chk = 0; hold_done = 0; hold_left = 0; held = '0; pos_before = '0;
    for (int i = 0; i < L; i++) begin
      pt_arr.push_back(ks_const ? 8'(i) : 8'($urandom));
      exp_q.push_back({i == L - 1, pt_arr[i] ^ ksfun(P + 32'(i / BB), i % BB)});
    end
    cfg_go = 1'b1; cfg_position = P;
    @(posedge clk);
    @(negedge clk);
    cfg_go = 1'b0;
    chk("go_to_start", core_start, 1);
    while (cyc < budget) begin
      if (core_start) begin
        n_start++; start_q.push_back(core_position);
        ks_pos = core_position; ks_idx = 0; ks_left = BB;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (stall_prev) begin
        chk("ct_hold_valid", ct_valid, 1);
        chk("ct_hold_dat", {ct_last, ct_byte}, held);
      end
      pt_valid = (pi < L) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      pt_byte  = (pi < L) ? pt_arr[pi] : 8'($urandom);
      pt_last  = (pi == L - 1);
      core_ks_valid = (ks_left > 0) && ($urandom_range(0, 3) != 0);
      core_ks_byte  = (ks_left > 0) ? ksfun(ks_pos, ks_idx) : 8'($urandom);
      if (hold_at >= 0 && pi == hold_at && !hold_done) begin hold_left = 10; hold_done = 1; end
      ct_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (hold_left > 0) hold_left--;
      go_chk = 0;
      if (go_at >= 0 && pi == go_at && !go_done) begin
        cfg_go = 1'b1; cfg_position = ~P; go_done = 1; go_chk = 1; pos_before = core_position;
      end
      #1;
      pt_hs = pt_valid && pt_ready;
      ks_hs = core_ks_valid && core_ks_ready;
      ct_hs = ct_valid && ct_ready;
      if (pi < L) chk("ks_pt_lockstep", ks_hs, pt_hs);
      else        chk("pt_ready_after_last", pt_ready, 0);
      if (ct_valid && !ct_ready) chk("pt_ready_stall", pt_ready, 0);
      stall_prev = ct_valid && !ct_ready;
      held = {ct_last, ct_byte};
      if (ct_hs) begin
        chk("ct_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("ct_dat", {ct_last, ct_byte}, exp_q.pop_front());
        n_ct++;
      end
      @(posedge clk);
      if (pt_hs) begin pi++; last_hs_cyc = cyc; end
      if (ks_hs) begin
        ks_idx++; ks_left--; last_hs_cyc = cyc;
        if (!pt_hs) n_drain++;
      end
      @(negedge clk);
      cfg_go = 1'b0;
      if (go_chk) chk("go_ignored_pos", core_position, pos_before);
      cyc++;
      if (abort_at >= 0 && pi == abort_at) break;
      if (!expect_err && n_done > 0 && exp_q.size() == 0 && cyc > done_cyc + 2) break;
    end
    pt_valid = 1'b0; core_ks_valid = 1'b0; ct_ready = 1'b1;
    if (abort_at >= 0) return;
    s0 = (start_q.size() > 0) ? start_q[0] : 32'hx;
    if (expect_err) begin
      chk("err_starts", n_start, 1);
      chk("err_start_pos", s0, P);
      chk("err_ct_cnt", n_ct, BB);
      chk("err_pt_stop", pi, BB);
      chk("err_flag", err_wrap, 1);
      chk("err_busy", busy, 1);
      chk("err_no_done", n_done, 0);
    end else begin
      exp_starts = (L + BB - 1) / BB;
      chk("msg_complete", (n_done > 0) && (exp_q.size() == 0), 1);
      chk("start_cnt", n_start, exp_starts);
      for (int k = 0; k < start_q.size() && k < exp_starts; k++)
        chk("start_pos", start_q[k], P + 32'(k));
      chk("done_cnt", n_done, 1);
      chk("done_timing", done_cyc, last_hs_cyc + 1);
      chk("drain_cnt", n_drain, (BB - L % BB) % BB);
      chk("ct_cnt", n_ct, L);
      chk("idle_busy", busy, 0);
      chk("no_err", err_wrap, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_go = 1'b0; cfg_position = '0;
    pt_valid = 1'b0; pt_byte = '0; pt_last = 1'b0;
    core_ks_valid = 1'b0; core_ks_byte = '0; ct_ready = 1'b1; ks_const = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("reset");

    // One full block, constant keystream, position 5 -> 6.
    ks_const = 1;
    run_msg(32'd5, 64, -1, -1, -1, 0, 2000);
    chk("t1_final_pos", core_position, 32'd6);
    ks_const = 0;

    // Three blocks with a 62-byte drain.
    run_msg(32'd5, 130, -1, -1, -1, 0, 4000);

    // Downstream stall of 10 cycles mid-block.
    run_msg(32'h1234_0000, 100, -1, -1, 30, 0, 4000);

    // cfg_go while streaming must be ignored.
    run_msg(32'h0000_0100, 100, -1, 10, -1, 0, 4000);

    // Random positions and lengths.
    for (int r = 0; r < 4; r++)
      run_msg($urandom, $urandom_range(1, 200), -1, -1, $urandom_range(0, 40), 0, 6000);

    // Reset mid-message at byte 20, then a clean restart.
    run_msg(32'h0000_0077, 100, 20, -1, -1, 0, 4000);
    chk("abort_reached", pi, 20);
    pulse_reset();
    chk_reset_vals("midreset");
    run_msg(32'h0000_0099, 70, -1, -1, -1, 0, 4000);

    // Position overflow: one block at all-ones, then ERR.
    run_msg(32'hFFFF_FFFF, 65, -1, -1, -1, 1, 400);
    pulse_reset();
    chk_reset_vals("errreset");
    run_msg(32'd3, 10, -1, -1, -1, 0, 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
